// File: rtl/cc_branch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Package     : slc3_cc_pkg
// Description : Condition-code type, one-hot CC constants and NZP derivation.
// Revision    : 1.0
// ============================================================================
package slc3_cc_pkg;

    typedef logic [2:0] cc_t;

    localparam cc_t CC_N     = 3'b100;
    localparam cc_t CC_Z     = 3'b010;
    localparam cc_t CC_P     = 3'b001;
    localparam cc_t CC_RESET = CC_Z;

    // Caller supplies its own sign bit and zero test, so any bus width works.
    function automatic cc_t nzp_of(input logic sign, input logic zero);
        if (zero)
            return CC_Z;
        else if (sign)
            return CC_N;
        else
            return CC_P;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_branch_unit_stack.sv
`default_nettype none
// ============================================================================
// Module      : cc_stack
// Description : Small LIFO of saved condition codes with occupancy flags.
// Revision    : 1.0
// ============================================================================
module cc_stack
    import slc3_cc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             push,
    input  logic             pop,
    input  cc_t              din,
    output cc_t              dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err_pulse
);

    localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    cc_t              mem [DEPTH];
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !pop && !full;
    assign do_pop  = pop && !push && !empty;

    // A simultaneous push and pop is treated as a conflict, not a swap.
    assign err_pulse = (push && pop) || (push && !pop && full) || (pop && !push && empty);

    assign wr_idx  = IDX_W'(count);
    assign top_idx = IDX_W'(count - CNT_W'(1));
    assign dout    = mem[top_idx];

    always_ff @(posedge Clk) begin
        if (Reset)
            count <= '0;
        else if (do_push)
            count <= count + CNT_W'(1);
        else if (do_pop)
            count <= count - CNT_W'(1);
    end

    always_ff @(posedge Clk) begin
        if (!Reset && do_push)
            mem[wr_idx] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/cc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : cc_branch_unit
// Description : SLC3 condition-code register, branch enable and saved-CC stack.
// Revision    : 1.0
// ============================================================================
module cc_branch_unit
    import slc3_cc_pkg::*;
#(
    parameter  int DATA_WIDTH  = 16,
    parameter  int STACK_DEPTH = 4,
    localparam int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DATA_WIDTH-1:0] Bus,
    input  logic                  LD_CC,
    input  logic                  LD_BEN,
    input  logic [2:0]            IR_nzp,
    input  logic                  CC_Push,
    input  logic                  CC_Pop,
    input  logic                  Err_Clr,
    output logic [2:0]            CC,
    output logic                  BEN,
    output logic [CNT_W-1:0]      Stack_Count,
    output logic                  Stack_Full,
    output logic                  Stack_Empty,
    output logic                  Stack_Err
);

    cc_t  bus_nzp;
    cc_t  stack_top;
    logic pop_ok;
    logic err_pulse;

    assign bus_nzp = nzp_of(Bus[DATA_WIDTH-1], Bus == '0);
    assign pop_ok  = CC_Pop && !CC_Push && !Stack_Empty;

    cc_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clk       (Clk),
        .Reset     (Reset),
        .push      (CC_Push),
        .pop       (CC_Pop),
        .din       (CC),
        .dout      (stack_top),
        .count     (Stack_Count),
        .full      (Stack_Full),
        .empty     (Stack_Empty),
        .err_pulse (err_pulse)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            CC        <= CC_RESET;
            BEN       <= 1'b0;
            Stack_Err <= 1'b0;
        end else begin
            // A restored CC wins over a same-cycle load from the bus.
            if (pop_ok)
                CC <= stack_top;
            else if (LD_CC)
                CC <= bus_nzp;

            if (LD_BEN)
                BEN <= |(IR_nzp & CC);

            if (err_pulse)
                Stack_Err <= 1'b1;
            else if (Err_Clr)
                Stack_Err <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cc_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_branch_unit
// Description : Scoreboard bench for cc_branch_unit at 16/4 and 8/2 configs.
// Revision    : 1.0
// ============================================================================
module tb_cc_branch_unit;

    typedef struct packed {
        logic [2:0] cc;
        logic       ben;
        logic [3:0] cnt;
        logic       full;
        logic       empty;
        logic       err;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] bus16;
    logic [7:0]  bus8;
    logic        ld_cc, ld_ben, cc_push, cc_pop, err_clr;
    logic [2:0]  ir_nzp;

    logic [2:0] cc_a, cc_b;
    logic       ben_a, ben_b, full_a, full_b, empty_a, empty_b, err_a, err_b;
    logic [2:0] cnt_a;
    logic [1:0] cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_a[$];
    exp_t sb_b[$];
    exp_t mon_a, mon_b;

    // Reference state: index 0 is the 16-bit/depth-4 unit, 1 the 8-bit/depth-2 unit.
    logic [2:0] m_cc  [2];
    logic       m_ben [2];
    logic       m_err [2];
    logic [2:0] m_stk [2][8];
    int         m_sz  [2];

    always #5 Clk = ~Clk;

    cc_branch_unit #(.DATA_WIDTH(16), .STACK_DEPTH(4)) dut_a (
        .Clk(Clk), .Reset(Reset), .Bus(bus16), .LD_CC(ld_cc), .LD_BEN(ld_ben),
        .IR_nzp(ir_nzp), .CC_Push(cc_push), .CC_Pop(cc_pop), .Err_Clr(err_clr),
        .CC(cc_a), .BEN(ben_a), .Stack_Count(cnt_a), .Stack_Full(full_a),
        .Stack_Empty(empty_a), .Stack_Err(err_a)
    );

    cc_branch_unit #(.DATA_WIDTH(8), .STACK_DEPTH(2)) dut_b (
        .Clk(Clk), .Reset(Reset), .Bus(bus8), .LD_CC(ld_cc), .LD_BEN(ld_ben),
        .IR_nzp(ir_nzp), .CC_Push(cc_push), .CC_Pop(cc_pop), .Err_Clr(err_clr),
        .CC(cc_b), .BEN(ben_b), .Stack_Count(cnt_b), .Stack_Full(full_b),
        .Stack_Empty(empty_b), .Stack_Err(err_b)
    );

    task automatic model(input int k, input int depth, input logic sign, input logic zero,
                         output exp_t e);
        logic [2:0] nzp;
        logic       evt;
        nzp = zero ? 3'b010 : (sign ? 3'b100 : 3'b001);
        evt = 1'b0;
        if (Reset) begin
            m_cc[k] = 3'b010; m_ben[k] = 1'b0; m_err[k] = 1'b0; m_sz[k] = 0;
        end else begin
            if (ld_ben) m_ben[k] = (ir_nzp & m_cc[k]) != 3'b000;
            if (cc_push && cc_pop) begin
                evt = 1'b1;
                if (ld_cc) m_cc[k] = nzp;
            end else if (cc_pop) begin
                if (m_sz[k] == 0) begin
                    evt = 1'b1;
                    if (ld_cc) m_cc[k] = nzp;
                end else begin
                    m_sz[k] = m_sz[k] - 1;
                    m_cc[k] = m_stk[k][m_sz[k]];
                end
            end else begin
                if (cc_push) begin
                    if (m_sz[k] == depth) evt = 1'b1;
                    else begin
                        m_stk[k][m_sz[k]] = m_cc[k];
                        m_sz[k] = m_sz[k] + 1;
                    end
                end
                if (ld_cc) m_cc[k] = nzp;
            end
            if (evt) m_err[k] = 1'b1;
            else if (err_clr) m_err[k] = 1'b0;
        end
        e.cc = m_cc[k]; e.ben = m_ben[k]; e.cnt = 4'(m_sz[k]);
        e.full = (m_sz[k] == depth); e.empty = (m_sz[k] == 0); e.err = m_err[k];
    endtask

    task automatic step(input logic rst, input logic lc, input logic lb, input logic [2:0] ir,
                        input logic ps, input logic pp, input logic ec,
                        input logic [15:0] b16, input logic [7:0] b8);
        exp_t ea, eb;
        Reset = rst; ld_cc = lc; ld_ben = lb; ir_nzp = ir;
        cc_push = ps; cc_pop = pp; err_clr = ec; bus16 = b16; bus8 = b8;
        model(0, 4, b16[15], b16 == 16'h0, ea);
        model(1, 2, b8[7], b8 == 8'h0, eb);
        @(posedge Clk);
        sb_a.push_back(ea);
        sb_b.push_back(eb);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (sb_a.size() > 0) begin
            mon_a = sb_a.pop_front();
            chk("a.cc", int'(cc_a), int'(mon_a.cc));
            chk("a.ben", int'(ben_a), int'(mon_a.ben));
            chk("a.count", int'(cnt_a), int'(mon_a.cnt));
            chk("a.full", int'(full_a), int'(mon_a.full));
            chk("a.empty", int'(empty_a), int'(mon_a.empty));
            chk("a.err", int'(err_a), int'(mon_a.err));
        end
        if (sb_b.size() > 0) begin
            mon_b = sb_b.pop_front();
            chk("b.cc", int'(cc_b), int'(mon_b.cc));
            chk("b.ben", int'(ben_b), int'(mon_b.ben));
            chk("b.count", int'(cnt_b), int'(mon_b.cnt));
            chk("b.full", int'(full_b), int'(mon_b.full));
            chk("b.empty", int'(empty_b), int'(mon_b.empty));
            chk("b.err", int'(err_b), int'(mon_b.err));
        end
    end

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 3))
            0:       return 16'h0000;
            1:       return 16'h8000 | 16'($urandom);
            2:       return 16'($urandom) & 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int budget;
        Reset = 1'b1; ld_cc = 0; ld_ben = 0; ir_nzp = 0; cc_push = 0; cc_pop = 0;
        err_clr = 0; bus16 = 0; bus8 = 0;

        //   rst lc lb ir      ps pp ec bus16     bus8
        step(1, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 8'h00);
        step(0, 1, 0, 3'b000, 0, 0, 0, 16'h8000, 8'h80);
        step(0, 0, 1, 3'b100, 0, 0, 0, 16'h0000, 8'h00);
        step(0, 0, 1, 3'b011, 0, 0, 0, 16'h0000, 8'h00);
        step(0, 1, 0, 3'b000, 0, 0, 0, 16'h0001, 8'h01);
        step(0, 1, 1, 3'b010, 0, 0, 0, 16'h0000, 8'h00);
        step(0, 0, 1, 3'b010, 0, 0, 0, 16'h0000, 8'h00);
        step(0, 0, 1, 3'b111, 0, 0, 0, 16'h0000, 8'h00);
        step(0, 0, 1, 3'b000, 0, 0, 0, 16'h0000, 8'h00);
        step(0, 1, 0, 3'b000, 0, 0, 0, 16'h0001, 8'h01);
        step(0, 1, 0, 3'b000, 1, 0, 0, 16'hFFFF, 8'hFF);
        step(0, 0, 0, 3'b000, 1, 0, 0, 16'h0000, 8'h00);
        step(0, 0, 0, 3'b000, 1, 0, 0, 16'h0000, 8'h00);
        step(0, 1, 0, 3'b000, 1, 0, 0, 16'h0000, 8'h00);
        step(0, 0, 0, 3'b000, 1, 0, 0, 16'h0000, 8'h00);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 3'b000, 0, 1, 0, 16'h0000, 8'h00);
        step(0, 1, 0, 3'b000, 0, 1, 0, 16'h0005, 8'h05);
        step(0, 0, 0, 3'b000, 0, 0, 1, 16'h0000, 8'h00);
        step(0, 1, 0, 3'b000, 0, 0, 0, 16'h8001, 8'h81);
        step(0, 0, 0, 3'b000, 1, 0, 0, 16'h0000, 8'h00);
        step(0, 1, 0, 3'b000, 1, 1, 0, 16'h0003, 8'h03);
        step(0, 1, 0, 3'b000, 0, 1, 1, 16'h0000, 8'h00);
        step(0, 1, 0, 3'b000, 1, 0, 0, 16'h0010, 8'h10);
        step(0, 1, 0, 3'b000, 1, 0, 0, 16'h8000, 8'h80);
        step(0, 1, 1, 3'b111, 1, 0, 0, 16'h0000, 8'h00);
        step(1, 1, 1, 3'b111, 1, 1, 0, 16'h8000, 8'h80);
        step(0, 0, 0, 3'b000, 0, 0, 0, 16'h0000, 8'h00);

        for (int i = 0; i < 600; i++) begin
            logic [15:0] b16;
            logic [7:0]  b8;
            b16 = pick16();
            b8  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 3'($urandom),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, b16, b8);
        end

        budget = 10;
        while ((sb_a.size() > 0 || sb_b.size() > 0) && budget > 0) begin
            @(negedge Clk);
            budget--;
        end
        #1;
        chk("drain", sb_a.size() + sb_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
